eth_tx_frame_arbiter: RTL and testbench

- Frame-level round-robin arbiter that shares the single TX AXI-stream input of the MII MAC/FIFO wrapper among N independent frame sources.
- Sits in the logic clock domain, directly upstream of the MAC wrapper's tx_axis port.
- A granted source keeps the grant until its tlast beat is accepted. Frames longer than the configured beat limit are truncated and marked bad (tuser=1) so the downstream frame FIFO drops them.

---
 rtl/eth_tx_arb_pkg.sv | 19 +
 rtl/eth_rr_select.sv | 30 +++
 rtl/eth_tx_frame_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_eth_tx_frame_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_tx_arb_pkg.sv
// Shared types and constants for the Ethernet TX frame arbiter.
// Holds the arbiter FSM encoding, the grant-index width helper and the statistics counter width.
package eth_tx_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      XFER  = 2'd1,
      DRAIN = 2'd2
   } arb_state_t;

   localparam int unsigned MAX_PORTS   = 16;
   localparam int unsigned GRANT_W_MAX = $clog2(MAX_PORTS);
   localparam int unsigned STAT_W      = 16;

   function automatic int unsigned grant_width(input int unsigned n_ports);
      return (n_ports > 1) ? $clog2(n_ports) : 1;
   endfunction

endpackage

// File: rtl/eth_rr_select.sv
// Combinational round-robin picker: first requester at or after (last_grant + 1) mod N_PORTS.
module eth_rr_select
   import eth_tx_arb_pkg::*;
#(
   parameter  int N_PORTS = 4,
   localparam int GW      = grant_width(N_PORTS)
) (
   input  logic [N_PORTS-1:0] req,
   input  logic [GW-1:0]      last_grant,
   output logic [GW-1:0]      sel,
   output logic               found
);

   logic [GW-1:0] idx;

   // NOTE: every output gets a default before the loop, otherwise always_comb infers latches.
   always_comb begin
      sel   = '0;
      found = 1'b0;
      idx   = '0;
      for (int i = 0; i < N_PORTS; i++) begin
         idx = GW'((int'(last_grant) + 1 + i) % N_PORTS);
         if (!found && req[idx]) begin
            found = 1'b1;
            sel   = idx;
         end
      end
   end

endmodule

// File: rtl/eth_tx_frame_arbiter.sv
// Frame-level round-robin arbiter feeding the MAC tx_axis port; truncates over-long frames as bad.
// Optional per-port frame/truncation counters are built when ETH_TX_ARB_STATS_EN is defined.
module eth_tx_frame_arbiter
   import eth_tx_arb_pkg::*;
#(
   parameter int N_PORTS         = 4,
   parameter int AXIS_DATA_WIDTH = 8,
   parameter int AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH / 8,
   parameter int MAX_FRAME_BEATS = 1518
) (
   input  logic                                 logic_clk,
   input  logic                                 logic_rst_n,
   input  logic [N_PORTS*AXIS_DATA_WIDTH-1:0]   s_axis_tdata,
   input  logic [N_PORTS*AXIS_KEEP_WIDTH-1:0]   s_axis_tkeep,
   input  logic [N_PORTS-1:0]                   s_axis_tvalid,
   output logic [N_PORTS-1:0]                   s_axis_tready,
   input  logic [N_PORTS-1:0]                   s_axis_tlast,
   input  logic [N_PORTS-1:0]                   s_axis_tuser,
   output logic [AXIS_DATA_WIDTH-1:0]           m_axis_tdata,
   output logic [AXIS_KEEP_WIDTH-1:0]           m_axis_tkeep,
   output logic                                 m_axis_tvalid,
   input  logic                                 m_axis_tready,
   output logic                                 m_axis_tlast,
   output logic                                 m_axis_tuser,
   input  logic [N_PORTS-1:0]                   port_enable,
   output logic [$clog2(N_PORTS)-1:0]           grant_id,
   output logic                                 busy,
`ifdef ETH_TX_ARB_STATS_EN
   output logic                                 trunc_event,
   input  logic                                 stat_clear,
   output logic [N_PORTS*STAT_W-1:0]            stat_frames,
   output logic [N_PORTS*STAT_W-1:0]            stat_trunc
`else
   output logic                                 trunc_event
`endif
);

   localparam int GW = $clog2(N_PORTS);
   localparam int CW = $clog2(MAX_FRAME_BEATS + 1);

   arb_state_t                 state;
   logic [GW-1:0]              last_grant;
   logic [GW-1:0]              sel;
   logic                       found;
   logic [CW-1:0]              beat_cnt;
   logic [N_PORTS-1:0]         req;
   logic [AXIS_DATA_WIDTH-1:0] data_arr [N_PORTS];
   logic [AXIS_KEEP_WIDTH-1:0] keep_arr [N_PORTS];
   logic [AXIS_DATA_WIDTH-1:0] src_data;
   logic [AXIS_KEEP_WIDTH-1:0] src_keep;
   logic                       src_valid;
   logic                       src_last;
   logic                       src_user;
   logic                       out_ready;
   logic                       accept;
   logic                       at_limit;
   logic                       frame_done;
   logic                       trunc_hit;

   assign req = s_axis_tvalid & port_enable;

   always_comb begin
      for (int i = 0; i < N_PORTS; i++) begin
         data_arr[i] = s_axis_tdata[i*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH];
         keep_arr[i] = s_axis_tkeep[i*AXIS_KEEP_WIDTH +: AXIS_KEEP_WIDTH];
      end
   end

   assign src_data  = data_arr[grant_id];
   assign src_keep  = keep_arr[grant_id];
   assign src_valid = s_axis_tvalid[grant_id];
   assign src_last  = s_axis_tlast[grant_id];
   assign src_user  = s_axis_tuser[grant_id];

   assign out_ready = !m_axis_tvalid || m_axis_tready;

   // DRAIN swallows the rest of a truncated frame regardless of downstream backpressure.
   always_comb begin
      s_axis_tready = '0;
      if (state == XFER)       s_axis_tready[grant_id] = out_ready;
      else if (state == DRAIN) s_axis_tready[grant_id] = 1'b1;
   end

   assign accept     = src_valid && s_axis_tready[grant_id];
   assign at_limit   = (beat_cnt == CW'(MAX_FRAME_BEATS - 1));
   assign frame_done = accept && src_last;
   assign trunc_hit  = (state == XFER) && accept && !src_last && at_limit;
   assign busy       = (state != IDLE);

   eth_rr_select #(.N_PORTS(N_PORTS)) u_rr_select (
      .req        (req),
      .last_grant (last_grant),
      .sel        (sel),
      .found      (found)
   );

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge logic_clk or negedge logic_rst_n) begin
      if (!logic_rst_n) begin
         state         <= IDLE;
         grant_id      <= '0;
         last_grant    <= GW'(N_PORTS - 1);  // first search after reset starts at port 0
         beat_cnt      <= '0;
         m_axis_tvalid <= 1'b0;
         m_axis_tdata  <= '0;
         m_axis_tkeep  <= '0;
         m_axis_tlast  <= 1'b0;
         m_axis_tuser  <= 1'b0;
         trunc_event   <= 1'b0;
      end else begin
         trunc_event <= 1'b0;
         if (m_axis_tvalid && m_axis_tready) m_axis_tvalid <= 1'b0;
         if (accept && state == XFER) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= src_data;
            m_axis_tkeep  <= src_keep;
            m_axis_tlast  <= src_last || trunc_hit;
            m_axis_tuser  <= src_user || trunc_hit;
         end
         case (state)
            IDLE: begin
               if (found) begin
                  grant_id <= sel;
                  beat_cnt <= '0;
                  state    <= XFER;
               end
            end
            XFER: begin
               if (frame_done) begin
                  beat_cnt   <= '0;
                  last_grant <= grant_id;
                  state      <= IDLE;
               end else if (trunc_hit) begin
                  beat_cnt    <= '0;
                  trunc_event <= 1'b1;
                  state       <= DRAIN;
               end else if (accept) begin
                  beat_cnt <= beat_cnt + 1'b1;
               end
            end
            DRAIN: begin
               if (frame_done) begin
                  last_grant <= grant_id;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef ETH_TX_ARB_STATS_EN
   logic [STAT_W-1:0] frames_q [N_PORTS];
   logic [STAT_W-1:0] trunc_q  [N_PORTS];

   // NOTE: these counter arrays are plain flops, not RAM, so resetting them is legitimate.
   always_ff @(posedge logic_clk or negedge logic_rst_n) begin
      if (!logic_rst_n) begin
         for (int i = 0; i < N_PORTS; i++) begin
            frames_q[i] <= '0;
            trunc_q[i]  <= '0;
         end
      end else if (stat_clear) begin
         for (int i = 0; i < N_PORTS; i++) begin
            frames_q[i] <= '0;
            trunc_q[i]  <= '0;
         end
      end else begin
         if (frame_done && frames_q[grant_id] != '1) frames_q[grant_id] <= frames_q[grant_id] + 1'b1;
         if (trunc_hit && trunc_q[grant_id] != '1)   trunc_q[grant_id]  <= trunc_q[grant_id] + 1'b1;
      end
   end

   always_comb begin
      stat_frames = '0;
      stat_trunc  = '0;
      for (int i = 0; i < N_PORTS; i++) begin
         stat_frames[i*STAT_W +: STAT_W] = frames_q[i];
         stat_trunc[i*STAT_W +: STAT_W]  = trunc_q[i];
      end
   end
`endif

endmodule

// File: tb/tb_eth_tx_frame_arbiter.sv
// Directed bench for eth_tx_frame_arbiter: frame-level scoreboard model plus per-cycle protocol checks.
module tb_eth_tx_frame_arbiter;

   localparam int NP   = 4;
   localparam int DW   = 8;
   localparam int KW   = 1;
   localparam int MAXB = 8;

   typedef struct packed {
      logic [1:0] port;
      logic [7:0] data;
      logic       keep;
      logic       last;
      logic       user;
   } beat_t;

   logic              logic_clk;
   logic              logic_rst_n;
   logic [NP*DW-1:0]  s_axis_tdata;
   logic [NP*KW-1:0]  s_axis_tkeep;
   logic [NP-1:0]     s_axis_tvalid;
   logic [NP-1:0]     s_axis_tready;
   logic [NP-1:0]     s_axis_tlast;
   logic [NP-1:0]     s_axis_tuser;
   logic [DW-1:0]     m_axis_tdata;
   logic [KW-1:0]     m_axis_tkeep;
   logic              m_axis_tvalid;
   logic              m_axis_tready;
   logic              m_axis_tlast;
   logic              m_axis_tuser;
   logic [NP-1:0]     port_enable;
   logic [1:0]        grant_id;
   logic              busy;
   logic              trunc_event;

   beat_t src_q [NP][$];
   beat_t mdl_q [NP][$];
   beat_t exp_q [$];

   int    vectors;
   int    miscompares;
   int    hs_count [NP];
   int    trunc_seen;
   int    exp_trunc;
   bit    gap_en, rdy_rand, chk_hold, gap_chk;
   bit    held, gap_pending;
   logic [10:0] prev_out;
   beat_t last_out, exp_beat;

   eth_tx_frame_arbiter #(
      .N_PORTS         (NP),
      .AXIS_DATA_WIDTH (DW),
      .AXIS_KEEP_WIDTH (KW),
      .MAX_FRAME_BEATS (MAXB)
   ) dut (
      .logic_clk     (logic_clk),
      .logic_rst_n   (logic_rst_n),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tkeep  (s_axis_tkeep),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .s_axis_tlast  (s_axis_tlast),
      .s_axis_tuser  (s_axis_tuser),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tkeep  (m_axis_tkeep),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tuser  (m_axis_tuser),
      .port_enable   (port_enable),
      .grant_id      (grant_id),
      .busy          (busy),
      .trunc_event   (trunc_event)
   );

   initial logic_clk = 1'b0;
   always #5 logic_clk = ~logic_clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic int pending();
      int n = 0;
      for (int p = 0; p < NP; p++) n += src_q[p].size();
      return n;
   endfunction

   task automatic load_frame(input int p, input int len, input logic [7:0] base, input logic user_last);
      beat_t b;
      for (int k = 0; k < len; k++) begin
         b.port = 2'(p);
         b.data = base + 8'(k);
         b.keep = 1'b1;
         b.last = (k == len - 1);
         b.user = (k == len - 1) ? user_last : 1'b0;
         src_q[p].push_back(b);
         mdl_q[p].push_back(b);
      end
   endtask

   // Model: the next frame of port p as it must appear downstream (truncated past MAXB beats).
   task automatic expect_grant(input int p);
      int    k = 0;
      bit    drop = 0;
      bit    orig_last;
      beat_t b;
      while (mdl_q[p].size() > 0) begin
         b = mdl_q[p].pop_front();
         k++;
         orig_last = b.last;
         if (!drop) begin
            if (!b.last && k == MAXB) begin
               b.last = 1'b1;
               b.user = 1'b1;
               drop   = 1'b1;
               exp_trunc++;
            end
            exp_q.push_back(b);
         end
         if (orig_last) break;
      end
   endtask

   function automatic logic [19:0] all_outputs();
      return {m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
              s_axis_tready, grant_id, busy, trunc_event};
   endfunction

   task automatic flush_model();
      for (int p = 0; p < NP; p++) begin
         src_q[p].delete();
         mdl_q[p].delete();
         hs_count[p] = 0;
      end
      exp_q.delete();
      trunc_seen = 0;
      exp_trunc  = 0;
   endtask

   task automatic do_reset();
      logic_rst_n = 1'b0;
      port_enable = '1;
      flush_model();
      repeat (2) @(negedge logic_clk);
      check("reset_state", all_outputs(), 20'd0);
      logic_rst_n = 1'b1;
   endtask

   task automatic wait_idle(input string name, input int left);
      int t = 0;
      while ((exp_q.size() != 0 || pending() != left) && t < 3000) begin
         @(negedge logic_clk);
         t++;
      end
      check({name, "_done"}, t < 3000, 1);
      repeat (3) @(negedge logic_clk);
      check({name, "_idle"}, {busy, m_axis_tvalid}, 2'b00);
      check({name, "_trunc"}, trunc_seen, exp_trunc);
   endtask

   task automatic wait_beats(input int p, input int n);
      int t = 0;
      while (hs_count[p] < n && t < 500) begin
         @(negedge logic_clk);
         t++;
      end
      check("wait_beats", t < 500, 1);
   endtask

   // Source and sink drivers update on the falling edge.
   always @(negedge logic_clk) begin
      for (int p = 0; p < NP; p++) begin
         if (src_q[p].size() > 0 && (!gap_en || $urandom_range(0, 3) != 0)) begin
            s_axis_tvalid[p]        = 1'b1;
            s_axis_tdata[p*DW +: DW] = src_q[p][0].data;
            s_axis_tkeep[p]         = src_q[p][0].keep;
            s_axis_tlast[p]         = src_q[p][0].last;
            s_axis_tuser[p]         = src_q[p][0].user;
         end else begin
            s_axis_tvalid[p]        = 1'b0;
            s_axis_tdata[p*DW +: DW] = '0;
            s_axis_tkeep[p]         = 1'b0;
            s_axis_tlast[p]         = 1'b0;
            s_axis_tuser[p]         = 1'b0;
         end
      end
      m_axis_tready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   // Compare process: samples one time unit before each rising edge.
   always @(negedge logic_clk) begin
      #4;
      if (!logic_rst_n) begin
         held        = 1'b0;
         gap_pending = 1'b0;
      end else begin
         if (gap_pending) begin
            check("frame_gap", m_axis_tvalid, 1'b0);
            gap_pending = 1'b0;
         end
         if (held)
            check("hold_stable", {m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser},
                  {1'b1, prev_out});
         check("tready_onehot", $countones(s_axis_tready) <= 1, 1);
         if (chk_hold && m_axis_tvalid && !m_axis_tready)
            check("tready_while_held", s_axis_tready, 4'b0000);
         for (int p = 0; p < NP; p++) begin
            if (s_axis_tvalid[p] && s_axis_tready[p]) begin
               hs_count[p]++;
               if (src_q[p].size() > 0) void'(src_q[p].pop_front());
            end
         end
         if (m_axis_tvalid && m_axis_tready) begin
            last_out.port = grant_id;
            last_out.data = m_axis_tdata;
            last_out.keep = m_axis_tkeep;
            last_out.last = m_axis_tlast;
            last_out.user = m_axis_tuser;
            if (exp_q.size() == 0) begin
               check("unexpected_beat", last_out, 13'd0);
            end else begin
               exp_beat = exp_q.pop_front();
               check("beat", last_out, exp_beat);
            end
            if (gap_chk && m_axis_tlast) gap_pending = 1'b1;
         end
         if (trunc_event) trunc_seen++;
         held     = m_axis_tvalid && !m_axis_tready;
         prev_out = {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser};
      end
   end

   initial begin
      vectors = 0; miscompares = 0;
      gap_en = 0; rdy_rand = 0; chk_hold = 0; gap_chk = 0;
      held = 0; gap_pending = 0;
      s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tvalid = '0;
      s_axis_tlast = '0; s_axis_tuser = '0; m_axis_tready = 1'b1;
      port_enable = '1;
      logic_rst_n = 1'b0;

      // Two simultaneous 4-beat frames: port 0 first, then port 2.
      do_reset();
      gap_chk = 1;
      load_frame(0, 4, 8'h10, 1'b0);
      load_frame(2, 4, 8'h20, 1'b1);
      expect_grant(0);
      expect_grant(2);
      wait_idle("two_ports", 0);

      // All ports streaming single-beat frames: strict 0,1,2,3 rotation for 12 frames.
      do_reset();
      for (int r = 0; r < 3; r++)
         for (int p = 0; p < NP; p++) load_frame(p, 1, 8'hA0 + 8'(r*4 + p), 1'b0);
      for (int r = 0; r < 3; r++)
         for (int p = 0; p < NP; p++) expect_grant(p);
      check("model_rr_len", exp_q.size(), 12);
      wait_idle("rr_single", 0);

      // 12-beat frame on port 1 truncated at beat 8; beats 9..12 drained.
      do_reset();
      gap_chk = 0;
      load_frame(1, 12, 8'h30, 1'b0);
      expect_grant(1);
      check("model_trunc_len", exp_q.size(), 8);
      check("model_trunc_cnt", exp_trunc, 1);
      wait_idle("truncate", 0);
      check("trunc_src_beats", hs_count[1], 12);
      check("trunc_last_beat", last_out, {2'd1, 8'h37, 1'b1, 1'b1, 1'b1});

      // 64 beats as eight exact-limit frames under random backpressure and source gaps.
      do_reset();
      gap_en = 1; rdy_rand = 1; chk_hold = 1;
      for (int f = 0; f < 8; f++) load_frame(1, MAXB, 8'(f*8), 1'b0);
      for (int f = 0; f < 8; f++) expect_grant(1);
      wait_idle("backpressure", 0);
      check("bp_src_beats", hs_count[1], 64);
      gap_en = 0; rdy_rand = 0; chk_hold = 0;

      // Port 3 disabled mid-frame: frame finishes, then port 3 waits until re-enabled.
      do_reset();
      load_frame(3, 5, 8'h40, 1'b0);
      load_frame(3, 5, 8'h48, 1'b0);
      expect_grant(3);
      wait_beats(3, 1);
      port_enable[3] = 1'b0;
      load_frame(1, 2, 8'h70, 1'b0);
      load_frame(1, 2, 8'h74, 1'b0);
      expect_grant(1);
      expect_grant(1);
      wait_idle("enable_off", 5);
      repeat (10) @(negedge logic_clk);
      check("port3_parked", {busy, 8'(src_q[3].size())}, {1'b0, 8'd5});
      port_enable[3] = 1'b1;
      expect_grant(3);
      wait_idle("enable_on", 0);

      // Reset mid-frame on port 2, then port 0 wins the post-reset arbitration.
      do_reset();
      gap_chk = 1;
      load_frame(2, 6, 8'h60, 1'b0);
      expect_grant(2);
      wait_beats(2, 3);
      #2;
      logic_rst_n = 1'b0;
      #1;
      check("reset_midframe", all_outputs(), 20'd0);
      flush_model();
      repeat (2) @(negedge logic_clk);
      logic_rst_n = 1'b1;
      load_frame(2, 3, 8'h80, 1'b0);
      load_frame(0, 2, 8'h90, 1'b0);
      expect_grant(0);
      expect_grant(2);
      wait_idle("post_reset", 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
